bp_fe_bp_resolve_queue: RTL

In-order branch resolution queue that feeds the training port of the gshare predictor. At fetch time it records each predicted branch's BHT read index and the taken/not-taken prediction. When the backend resolves branches in program order, it pops the oldest entry, compares the prediction with the actual outcome, and drives a registered one-cycle update of `w_v`/`idx_w`/`correct` into the predictor. It also tracks occupancy and counts mispredictions, and discards wrong-path entries on flush.

---
 rtl/bp_fe_bp_resolve_queue.sv | 115 +++++++++++
 1 files changed

// File: rtl/bp_fe_bp_resolve_queue.sv
// In-order branch resolution queue feeding the gshare predictor training port.
// Records {bht index, predicted direction} at fetch, pops the oldest entry on
// resolve, and emits a registered one-cycle predictor update.
module bp_fe_bp_resolve_queue #(
    parameter int bht_idx_width_p = 8,
    parameter int depth_p         = 8,
    parameter int cnt_width_p     = 16
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         enq_v_i,
    input  logic [bht_idx_width_p-1:0]   enq_idx_i,
    input  logic                         enq_pred_i,
    output logic                         enq_ready_o,
    input  logic                         resolve_v_i,
    input  logic                         resolve_taken_i,
    output logic                         resolve_ready_o,
    input  logic                         flush_i,
    output logic                         w_v_o,
    output logic [bht_idx_width_p-1:0]   idx_w_o,
    output logic                         correct_o,
    output logic                         mispredict_o,
    output logic                         empty_o,
    output logic                         full_o,
    output logic [$clog2(depth_p):0]     occupancy_o,
    output logic [cnt_width_p-1:0]       mispredict_cnt_o
);

    localparam int PW = $clog2(depth_p);
    localparam int CW = PW + 1;

    logic [bht_idx_width_p:0]   mem_q [depth_p];
    logic [PW-1:0]              wp_q, wp_d;
    logic [PW-1:0]              rp_q, rp_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic                       w_v_q;
    logic [bht_idx_width_p-1:0] idx_w_q;
    logic                       correct_q;
    logic [cnt_width_p-1:0]     mcnt_q;

    logic                       enq_acc, res_acc;
    logic [bht_idx_width_p:0]   head;

    assign full_o          = (cnt_q == CW'(depth_p));
    assign empty_o         = (cnt_q == '0);
    assign enq_ready_o     = ~full_o;
    assign resolve_ready_o = ~empty_o;
    assign occupancy_o     = cnt_q;

    assign enq_acc = enq_v_i & ~full_o & ~flush_i;
    assign res_acc = resolve_v_i & ~empty_o;
    assign head    = mem_q[rp_q];

    assign w_v_o            = w_v_q;
    assign idx_w_o          = idx_w_q;
    assign correct_o        = correct_q;
    assign mispredict_o     = w_v_q & ~correct_q;
    assign mispredict_cnt_o = mcnt_q;

    // Next pointer/count; flush discards everything left after the resolve.
    always_comb begin
        wp_d  = wp_q + PW'(enq_acc);
        rp_d  = rp_q + PW'(res_acc);
        cnt_d = cnt_q + CW'(enq_acc) - CW'(res_acc);
        if (flush_i) begin
            rp_d  = wp_q;
            cnt_d = '0;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry storage; contents need no reset.
    always_ff @(posedge clk_i) begin
        if (enq_acc) begin
            mem_q[wp_q] <= {enq_idx_i, enq_pred_i};
        end
    end

    // Registered predictor update; index/correct hold when idle.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            w_v_q     <= 1'b0;
            idx_w_q   <= '0;
            correct_q <= 1'b0;
        end else begin
            w_v_q <= res_acc;
            if (res_acc) begin
                idx_w_q   <= head[bht_idx_width_p:1];
                correct_q <= (head[0] == resolve_taken_i);
            end
        end
    end

    // Saturating misprediction counter.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            mcnt_q <= '0;
        end else if (mispredict_o && (mcnt_q != '1)) begin
            mcnt_q <= mcnt_q + 1'b1;
        end
    end

endmodule
